alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu.sv | 156 +++++++++++++++
 tb/tb_alu.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// 8-bit registered ALU: 16 opcodes, zero/carry/parity/sign flags, one-cycle latency.
// Optional signed-overflow output flagv is enabled by defining ALU_OVERFLOW_FLAG_EN.
module alu (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [3:0] D,
  output logic [7:0] out,
  output logic       flagz,
  output logic       flagc,
  output logic       flagp,
  output logic       flags
`ifdef ALU_OVERFLOW_FLAG_EN
  ,
  output logic       flagv
`endif
);

  localparam int unsigned W = 8;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOT  = 4'd5,
    OP_NAND = 4'd6,
    OP_NOR  = 4'd7,
    OP_XNOR = 4'd8,
    OP_INC  = 4'd9,
    OP_DEC  = 4'd10,
    OP_SHL  = 4'd11,
    OP_SHR  = 4'd12,
    OP_ROL  = 4'd13,
    OP_ROR  = 4'd14,
    OP_ASR  = 4'd15
  } op_t;

  op_t          op_c;
  logic [W:0]   wide_c;
  logic [W-1:0] res_c;
  logic         carry_c;
  logic         zero_c;
  logic         par_c;
  logic         sign_c;

  assign op_c = op_t'(D);

  // Result and carry/borrow/shifted-out bit; arithmetic uses a 9-bit path.
  always_comb begin
    wide_c  = '0;
    res_c   = '0;
    carry_c = 1'b0;
    case (op_c)
      OP_ADD: begin
        wide_c  = {1'b0, A} + {1'b0, B};
        res_c   = wide_c[W-1:0];
        carry_c = wide_c[W];
      end
      OP_SUB: begin
        wide_c  = {1'b0, A} - {1'b0, B};
        res_c   = wide_c[W-1:0];
        carry_c = wide_c[W];
      end
      OP_AND:  res_c = A & B;
      OP_OR:   res_c = A | B;
      OP_XOR:  res_c = A ^ B;
      OP_NOT:  res_c = ~A;
      OP_NAND: res_c = ~(A & B);
      OP_NOR:  res_c = ~(A | B);
      OP_XNOR: res_c = ~(A ^ B);
      OP_INC: begin
        wide_c  = {1'b0, A} + (W+1)'(1);
        res_c   = wide_c[W-1:0];
        carry_c = wide_c[W];
      end
      OP_DEC: begin
        wide_c  = {1'b0, A} - (W+1)'(1);
        res_c   = wide_c[W-1:0];
        carry_c = wide_c[W];
      end
      OP_SHL: begin
        res_c   = {A[W-2:0], 1'b0};
        carry_c = A[W-1];
      end
      OP_SHR: begin
        res_c   = {1'b0, A[W-1:1]};
        carry_c = A[0];
      end
      OP_ROL: begin
        res_c   = {A[W-2:0], A[W-1]};
        carry_c = A[W-1];
      end
      OP_ROR: begin
        res_c   = {A[0], A[W-1:1]};
        carry_c = A[0];
      end
      OP_ASR: begin
        res_c   = {A[W-1], A[W-1:1]};
        carry_c = A[0];
      end
      default: begin
        res_c   = '0;
        carry_c = 1'b0;
      end
    endcase
  end

  assign zero_c = (res_c == '0);
  assign par_c  = ~(^res_c);
  assign sign_c = res_c[W-1];

  // Output register; reset value reflects a zero result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out   <= '0;
      flagz <= 1'b1;
      flagc <= 1'b0;
      flagp <= 1'b1;
      flags <= 1'b0;
    end else begin
      out   <= res_c;
      flagz <= zero_c;
      flagc <= carry_c;
      flagp <= par_c;
      flags <= sign_c;
    end
  end

`ifdef ALU_OVERFLOW_FLAG_EN
  logic ovf_c;

  // Signed overflow: only the add/subtract family can overflow.
  always_comb begin
    ovf_c = 1'b0;
    case (op_c)
      OP_ADD:  ovf_c = (A[W-1] == B[W-1]) && (res_c[W-1] != A[W-1]);
      OP_SUB:  ovf_c = (A[W-1] != B[W-1]) && (res_c[W-1] != A[W-1]);
      OP_INC:  ovf_c = (A == 8'h7F);
      OP_DEC:  ovf_c = (A == 8'h80);
      default: ovf_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flagv <= 1'b0;
    end else begin
      flagv <= ovf_c;
    end
  end
`endif

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: stimulus pushes expected results, a monitor pops one per edge.
module tb_alu;

  typedef struct packed {
    logic [7:0] out;
    logic       z;
    logic       c;
    logic       p;
    logic       s;
    logic       v;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] A;
  logic [7:0] B;
  logic [3:0] D;
  logic [7:0] out;
  logic       flagz, flagc, flagp, flags;
`ifdef ALU_OVERFLOW_FLAG_EN
  logic       flagv;
`endif

  int   n_vec = 0;
  int   n_err = 0;
  exp_t q[$];
  exp_t last_exp;

  alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .D     (D),
    .out   (out),
    .flagz (flagz),
    .flagc (flagc),
    .flagp (flagp),
    .flags (flags)
`ifdef ALU_OVERFLOW_FLAG_EN
    ,
    .flagv (flagv)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [7:0] o, input logic c, input logic v);
    exp_t e;
    e.out = o;
    e.z   = (o == 8'h00);
    e.c   = c;
    e.p   = ~(^o);
    e.s   = o[7];
    e.v   = v;
    return e;
  endfunction

  // Independent reference for the sweep, written from the opcode table.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] d);
    int unsigned sa, sb, r;
    logic [7:0]  o;
    logic        c, v;
    int          si;
    sa = a; sb = b; c = 1'b0; v = 1'b0; o = 8'h00;
    case (d)
      4'd0:  begin r = sa + sb; o = r[7:0]; c = (r > 255);
                   si = $signed(a) + $signed(b); v = (si > 127) || (si < -128); end
      4'd1:  begin o = 8'(sa - sb); c = (sa < sb);
                   si = $signed(a) - $signed(b); v = (si > 127) || (si < -128); end
      4'd2:  o = a & b;
      4'd3:  o = a | b;
      4'd4:  o = a ^ b;
      4'd5:  o = ~a;
      4'd6:  o = ~(a & b);
      4'd7:  o = ~(a | b);
      4'd8:  o = ~(a ^ b);
      4'd9:  begin o = 8'(sa + 1); c = (sa == 255); v = (a == 8'h7F); end
      4'd10: begin o = 8'(sa - 1); c = (sa == 0);   v = (a == 8'h80); end
      4'd11: begin o = a << 1; c = a[7]; end
      4'd12: begin o = a >> 1; c = a[0]; end
      4'd13: begin o = (a << 1) | (a >> 7); c = a[7]; end
      4'd14: begin o = (a >> 1) | (a << 7); c = a[0]; end
      default: begin o = 8'($signed(a) >>> 1); c = a[0]; end
    endcase
    return mk(o, c, v);
  endfunction

  task automatic check(input string name, input exp_t e);
    exp_t act;
    act.out = out; act.z = flagz; act.c = flagc; act.p = flagp; act.s = flags;
`ifdef ALU_OVERFLOW_FLAG_EN
    act.v = flagv;
`else
    act.v = e.v;
`endif
    n_vec++;
    if (act !== e) begin
      n_err++;
      $display("FAIL %s: got out=%h z=%b c=%b p=%b s=%b v=%b, want out=%h z=%b c=%b p=%b s=%b v=%b",
               name, act.out, act.z, act.c, act.p, act.s, act.v,
               e.out, e.z, e.c, e.p, e.s, e.v);
    end
  endtask

  // Monitor: one result per rising edge while out of reset.
  always @(posedge clk) begin
    #1;
    if (rst_n && q.size() > 0) begin
      last_exp = q.pop_front();
      check("result", last_exp);
    end
  end

  // Drive at a falling edge; result appears after the next rising edge.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] d, input exp_t e);
    A = a; B = b; D = d;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() > 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d results still pending, want 0", q.size());
      q.delete();
    end
  endtask

  exp_t rst_e;
  exp_t sw_tab[16];

  initial begin
    rst_e = mk(8'h00, 1'b0, 1'b0);
    sw_tab[0]  = mk(8'h5D, 1'b1, 1'b0);
    sw_tab[1]  = mk(8'h97, 1'b0, 1'b0);
    sw_tab[2]  = mk(8'h62, 1'b0, 1'b0);
    sw_tab[3]  = mk(8'hFB, 1'b0, 1'b0);
    sw_tab[4]  = mk(8'h99, 1'b0, 1'b0);
    sw_tab[5]  = mk(8'h05, 1'b0, 1'b0);
    sw_tab[6]  = mk(8'h9D, 1'b0, 1'b0);
    sw_tab[7]  = mk(8'h04, 1'b0, 1'b0);
    sw_tab[8]  = mk(8'h66, 1'b0, 1'b0);
    sw_tab[9]  = mk(8'hFB, 1'b0, 1'b0);
    sw_tab[10] = mk(8'hF9, 1'b0, 1'b0);
    sw_tab[11] = mk(8'hF4, 1'b1, 1'b0);
    sw_tab[12] = mk(8'h7D, 1'b0, 1'b0);
    sw_tab[13] = mk(8'hF5, 1'b1, 1'b0);
    sw_tab[14] = mk(8'h7D, 1'b0, 1'b0);
    sw_tab[15] = mk(8'hFD, 1'b0, 1'b0);

    rst_n = 1'b0;
    A = 8'h00; B = 8'h00; D = 4'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      A = 8'($urandom); B = 8'($urandom); D = 4'($urandom);
      @(posedge clk);
      #1 check("reset_hold", rst_e);
    end

    @(negedge clk);
    rst_n = 1'b1;
    issue(8'hFA, 8'h63, 4'd0,  mk(8'h5D, 1'b1, 1'b0));
    issue(8'hFA, 8'h63, 4'd1,  mk(8'h97, 1'b0, 1'b0));
    issue(8'hFA, 8'h63, 4'd2,  mk(8'h62, 1'b0, 1'b0));
    issue(8'hFA, 8'h63, 4'd4,  mk(8'h99, 1'b0, 1'b0));
    issue(8'hFA, 8'h63, 4'd11, mk(8'hF4, 1'b1, 1'b0));
    issue(8'hFA, 8'h63, 4'd15, mk(8'hFD, 1'b0, 1'b0));
    issue(8'hFF, 8'h00, 4'd9,  mk(8'h00, 1'b1, 1'b0));
    issue(8'h55, 8'h55, 4'd1,  mk(8'h00, 1'b0, 1'b0));
    issue(8'h00, 8'h00, 4'd10, mk(8'hFF, 1'b1, 1'b0));
    issue(8'h7F, 8'h01, 4'd0,  mk(8'h80, 1'b0, 1'b1));
    issue(8'h80, 8'h01, 4'd1,  mk(8'h7F, 1'b0, 1'b1));
    issue(8'h7F, 8'h00, 4'd9,  mk(8'h80, 1'b0, 1'b1));
    issue(8'h80, 8'h00, 4'd10, mk(8'h7F, 1'b0, 1'b1));
    for (int d = 0; d < 16; d++) issue(8'hFA, 8'h63, 4'(d), sw_tab[d]);
    for (int d = 0; d < 16; d++) issue(8'h81, 8'hC3, 4'(d), model(8'h81, 8'hC3, 4'(d)));
    drain();

    // Inputs moving between edges must not disturb the registered result.
    @(posedge clk);
    #3;
    A = 8'($urandom); B = 8'($urandom); D = 4'($urandom);
    #1 check("hold_between_edges", last_exp);

    // Mid-cycle async reset with an operation in flight.
    @(negedge clk);
    A = 8'h12; B = 8'h34; D = 4'd0;
    #2 rst_n = 1'b0;
    q.delete();
    #1 check("async_reset", rst_e);
    @(posedge clk);
    #1 check("reset_discard", rst_e);

    // First edge after release captures normally.
    @(negedge clk);
    rst_n = 1'b1;
    issue(8'h0F, 8'h01, 4'd0, mk(8'h10, 1'b0, 1'b0));
    issue(8'hC3, 8'h00, 4'd13, mk(8'h87, 1'b1, 1'b0));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
